// File: rtl/period_seq_8bit.sv
// Period-table sequencer: steps through a small table of 8-bit periods, issuing
// a load then re_load strobe per entry and advancing on the counter stage's tc.
module period_seq_8bit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] last_idx,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    input  logic          tc_in,
    output logic [7:0]    data_out,
    output logic          load,
    output logic          re_load,
    output logic          busy,
    output logic [AW-1:0] seq_idx,
    output logic          done
);

    localparam int unsigned DW = 8;
    localparam logic [AW-1:0] IDX0 = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ARM  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_table [DEPTH];
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic [AW-1:0] w_idx_inc;
    logic [AW-1:0] r_last_idx;
    logic [AW-1:0] w_last_idx_nxt;
    logic          r_loop_en;
    logic          w_loop_en_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;
    logic          r_load;
    logic          r_re_load;
    logic          r_busy;
    logic          r_done;
    logic          w_done_nxt;

    // Period table; reads in the same cycle see the pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_table[i] <= '0;
            end
        end else if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_last_idx_nxt = r_last_idx;
        w_loop_en_nxt  = r_loop_en;
        w_data_nxt     = r_data;
        w_done_nxt     = 1'b0;
        w_idx_inc      = r_idx + AW'(1);

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt    = S_LOAD;
                    w_last_idx_nxt = last_idx;
                    w_loop_en_nxt  = loop_en;
                    w_idx_nxt      = IDX0;
                    w_data_nxt     = r_table[IDX0];
                end
            end
            S_LOAD: begin
                w_state_nxt = stop ? S_IDLE : S_ARM;
            end
            S_ARM: begin
                w_state_nxt = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (tc_in) begin
                    if (r_idx < r_last_idx) begin
                        w_state_nxt = S_LOAD;
                        w_idx_nxt   = w_idx_inc;
                        w_data_nxt  = r_table[w_idx_inc];
                    end else if (r_loop_en) begin
                        w_state_nxt = S_LOAD;
                        w_idx_nxt   = IDX0;
                        w_data_nxt  = r_table[IDX0];
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_loop_en  <= 1'b0;
            r_data     <= '0;
            r_load     <= 1'b0;
            r_re_load  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_loop_en  <= w_loop_en_nxt;
            r_data     <= w_data_nxt;
            r_load     <= (w_state_nxt == S_LOAD);
            r_re_load  <= (w_state_nxt == S_ARM);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign data_out = r_data;
    assign load     = r_load;
    assign re_load  = r_re_load;
    assign busy     = r_busy;
    assign seq_idx  = r_idx;
    assign done     = r_done;

endmodule

// File: tb/tb_period_seq_8bit.sv
// Bench for period_seq_8bit: directed scenarios plus random traffic, each cycle
// compared against an entry-level behavioural model.
module tb_period_seq_8bit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned VW    = 8 + 4 + AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] last_idx;
    logic          loop_en;
    logic          start;
    logic          stop;
    logic          tc_in;
    logic [7:0]    data_out;
    logic          load;
    logic          re_load;
    logic          busy;
    logic [AW-1:0] seq_idx;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: an entry is "issued" at an edge; age 1 = load cycle, 2 = re_load, 3 = waiting for tc
    logic [7:0] m_tbl [DEPTH];
    bit         m_active;
    int         m_age;
    int         m_idx;
    int         m_last;
    bit         m_loop;
    logic [7:0] m_data;
    bit         m_done;

    always #5 clk = ~clk;

    period_seq_8bit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .last_idx(last_idx), .loop_en(loop_en), .start(start), .stop(stop), .tc_in(tc_in),
        .data_out(data_out), .load(load), .re_load(re_load), .busy(busy),
        .seq_idx(seq_idx), .done(done)
    );

    function automatic logic [VW-1:0] exp_vec();
        return {m_data, 1'(m_active && m_age == 1), 1'(m_active && m_age == 2),
                m_active, AW'(m_idx), m_done};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {data_out, load, re_load, busy, seq_idx, done};
    endfunction

    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_idx = 0; m_last = 0; m_loop = 1'b0; m_data = '0;
            for (int i = 0; i < int'(DEPTH); i++) m_tbl[i] = '0;
            return;
        end
        if (!m_active) begin
            if (start && !stop) begin
                m_last = int'(last_idx); m_loop = loop_en; m_idx = 0;
                m_data = m_tbl[0]; m_active = 1'b1; m_age = 1;
            end
        end else if (stop) begin
            m_active = 1'b0;
        end else if (m_age >= 3 && tc_in) begin
            if (m_idx < m_last) begin
                m_idx = m_idx + 1; m_data = m_tbl[m_idx]; m_age = 1;
            end else if (m_loop) begin
                m_idx = 0; m_data = m_tbl[0]; m_age = 1;
            end else begin
                m_active = 1'b0; m_done = 1'b1;
            end
        end else if (m_age < 3) begin
            m_age = m_age + 1;
        end
        if (wr_en) m_tbl[wr_addr] = wr_data;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic clr_in();
        rst = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0; tc_in = 1'b0;
    endtask

    task automatic write_tbl(input logic [AW-1:0] a, input logic [7:0] d);
        clr_in(); wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        clr_in();
    endtask

    task automatic load_std_table();
        write_tbl(2'd0, 8'h05); write_tbl(2'd1, 8'h0A);
        write_tbl(2'd2, 8'h03); write_tbl(2'd3, 8'hFF);
    endtask

    task automatic test_reset();
        clr_in(); rst = 1'b1; wr_addr = '0; wr_data = '0; last_idx = '0; loop_en = 1'b0;
        cycle();
        n_checks++;
        if (obs_vec() !== VW'(0)) begin
            n_fail++; $display("FAIL reset_state got %h exp %h", obs_vec(), VW'(0));
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model got %h exp %h", obs_vec(), exp_vec());
        end
        clr_in();
    endtask

    task automatic test_one_shot();
        logic [7:0] loads[$];
        int dones = 0;
        bit prev_load = 1'b0;
        bit finished = 1'b0;
        load_std_table();
        last_idx = 2'd2; loop_en = 1'b0;
        for (int c = 0; c < 100 && !finished; c++) begin
            clr_in();
            if (c == 0) start = 1'b1;
            tc_in = m_active && m_age >= 3 && ($urandom_range(0, 2) == 0);
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL one_shot cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
            end
            n_checks++;
            if (re_load !== prev_load) begin
                n_fail++; $display("FAIL one_shot_reload_after_load cyc %0d got %b exp %b", cyc, re_load, prev_load);
            end
            prev_load = load;
            if (load) loads.push_back(data_out);
            if (done) dones++;
            if (dones > 0 && !busy) finished = 1'b1;
        end
        n_checks++;
        if (loads.size() != 3 || {loads[0], loads[1], loads[2]} !== 24'h050A03) begin
            n_fail++; $display("FAIL one_shot_loads got %0d loads exp 3 (05,0A,03)", loads.size());
        end
        n_checks++;
        if (dones != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL one_shot_done got dones=%0d busy=%b exp dones=1 busy=0", dones, busy);
        end
    endtask

    task automatic test_loop();
        logic [7:0]    loads[$];
        logic [AW-1:0] idxs[$];
        int  tcs = 0;
        int  dones = 0;
        bit  finished = 1'b0;
        last_idx = 2'd1; loop_en = 1'b1;
        for (int c = 0; c < 150 && !finished; c++) begin
            clr_in();
            if (c == 0) start = 1'b1;
            if (m_active && m_age >= 3) begin
                if (tcs < 5) begin
                    tc_in = ($urandom_range(0, 1) == 0);
                    if (tc_in) tcs++;
                end else begin
                    stop = 1'b1; finished = 1'b1;
                end
            end
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL loop cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
            end
            if (load) begin loads.push_back(data_out); idxs.push_back(seq_idx); end
            if (done) dones++;
        end
        n_checks++;
        if (loads.size() != 6 || {loads[0], loads[1], loads[2], loads[3], loads[4], loads[5]} !== 48'h050A050A050A) begin
            n_fail++; $display("FAIL loop_loads got %0d loads exp 6 (05,0A x3)", loads.size());
        end
        n_checks++;
        if (idxs.size() != 6 || {idxs[0], idxs[1], idxs[2], idxs[3], idxs[4], idxs[5]} !== 12'b00_01_00_01_00_01) begin
            n_fail++; $display("FAIL loop_idx_wrap got %0d entries exp 0,1,0,1,0,1", idxs.size());
        end
        n_checks++;
        if (dones != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL loop_no_done got dones=%0d busy=%b exp 0/0", dones, busy);
        end
    endtask

    task automatic test_stop();
        int  strobes = 0;
        bit  stopped = 1'b0;
        last_idx = 2'd3; loop_en = 1'b0;
        for (int c = 0; c < 100 && !stopped; c++) begin
            clr_in();
            if (c == 0) start = 1'b1;
            if (m_active && m_age >= 3) begin
                if (m_idx == 0) tc_in = 1'b1;
                else if ($urandom_range(0, 2) == 0) begin stop = 1'b1; tc_in = 1'b1; stopped = 1'b1; end
            end
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stop cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (!stopped || busy !== 1'b0 || done !== 1'b0 || seq_idx !== 2'd1) begin
            n_fail++; $display("FAIL stop_idle got busy=%b done=%b idx=%0d exp 0/0/1", busy, done, seq_idx);
        end
        for (int c = 0; c < 6; c++) begin
            clr_in(); tc_in = 1'b1; stop = c[0];
            cycle();
            if (load || re_load || done) strobes++;
        end
        n_checks++;
        if (strobes != 0 || seq_idx !== 2'd1) begin
            n_fail++; $display("FAIL stop_quiet got strobes=%0d idx=%0d exp 0/1", strobes, seq_idx);
        end
        clr_in(); start = 1'b1;
        cycle();
        n_checks++;
        if (load !== 1'b1 || data_out !== 8'h05 || seq_idx !== 2'd0) begin
            n_fail++; $display("FAIL stop_restart got load=%b data=%h idx=%0d exp 1/05/0", load, data_out, seq_idx);
        end
        clr_in(); stop = 1'b1;
        cycle();
        clr_in();
    endtask

    task automatic test_ignore();
        logic [VW-1:0] got;
        for (int c = 0; c < 14; c++) begin
            clr_in(); last_idx = 2'd2; loop_en = 1'b0;
            case (c)
                0: start = 1'b1;
                1, 2: tc_in = 1'b1;
                3, 4, 5: begin start = 1'b1; last_idx = 2'd0; loop_en = 1'b1; end
                6, 9, 12: tc_in = 1'b1;
                default: ;
            endcase
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL ignore cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
            end
            got = obs_vec();
            n_checks++;
            if ((c == 1 && {load, re_load, seq_idx} !== 4'b0100) ||
                (c == 2 && {load, re_load, busy} !== 3'b001) ||
                (c == 5 && {load, seq_idx, busy} !== 4'b0001) ||
                (c == 6 && {load, data_out, seq_idx} !== {1'b1, 8'h0A, 2'd1}) ||
                (c == 9 && {load, data_out, seq_idx} !== {1'b1, 8'h03, 2'd2}) ||
                (c == 12 && {done, busy} !== 2'b10) ||
                (c == 13 && {done, busy} !== 2'b00)) begin
                n_fail++; $display("FAIL ignore_timing step %0d got %h", c, got);
            end
        end
    endtask

    task automatic test_rbw();
        for (int c = 0; c < 11; c++) begin
            clr_in(); last_idx = 2'd1; loop_en = 1'b1;
            case (c)
                0: start = 1'b1;
                3: begin tc_in = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h77; end
                6, 9: tc_in = 1'b1;
                10: stop = 1'b1;
                default: ;
            endcase
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rbw cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
            end
            if (c == 3 || c == 9) begin
                n_checks++;
                if (load !== 1'b1 || data_out !== ((c == 3) ? 8'h0A : 8'h77)) begin
                    n_fail++; $display("FAIL rbw_value step %0d got load=%b data=%h exp 1/%h",
                                       c, load, data_out, (c == 3) ? 8'h0A : 8'h77);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        last_idx = 2'd3; loop_en = 1'b0;
        for (int c = 0; c < 9; c++) begin
            clr_in();
            case (c)
                0, 4: start = 1'b1;
                3: rst = 1'b1;
                8: stop = 1'b1;
                default: ;
            endcase
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
            end
            if (c == 3) begin
                n_checks++;
                if (obs_vec() !== VW'(0)) begin
                    n_fail++; $display("FAIL reset_mid_zero got %h exp %h", obs_vec(), VW'(0));
                end
            end
            if (c == 4) begin
                n_checks++;
                if (load !== 1'b1 || data_out !== 8'h00) begin
                    n_fail++; $display("FAIL reset_mid_cleared got load=%b data=%h exp 1/00", load, data_out);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            clr_in();
            rst      = ($urandom_range(0, 199) == 0);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = AW'($urandom);
            wr_data  = 8'($urandom);
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            tc_in    = ($urandom_range(0, 2) == 0);
            last_idx = AW'($urandom);
            loop_en  = 1'($urandom);
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec() || (load && re_load)) begin
                n_fail++; $display("FAIL random cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
            end
        end
        clr_in();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_shot();
        test_loop();
        test_stop();
        test_ignore();
        test_rbw();
        load_std_table();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/period_seq_8bit.md
Name: period_seq_8bit

Overview:
Upstream sequencer for the 8-bit counter/register stage. Holds a small table of 8-bit period values and steps through it: for each entry it drives data_out with a one-cycle load strobe, then a one-cycle re_load strobe. It then waits for the counter stage's terminal-count pulse (tc_in) before advancing. Supports one-shot and looping sequences, abort, and a completion pulse.

Parameters:
DEPTH, 4, number of table entries (power of two, 2..16)
AW, 2, table address width, log2(DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  table write strobe
wr_addr  input  AW  table write address
wr_data  input  8  table write data
last_idx  input  AW  index of final entry in sequence; sampled on accepted start
loop_en  input  1  1 = wrap to entry 0 after last entry; sampled on accepted start
start  input  1  begin sequence (level-sampled, accepted only in IDLE)
stop  input  1  abort sequence
tc_in  input  1  terminal-count pulse from counter stage
data_out  output  8  period value presented to counter stage register
load  output  1  one-cycle strobe: counter stage captures data_out
re_load  output  1  one-cycle strobe: counter stage restarts from captured value
busy  output  1  high in every state except IDLE
seq_idx  output  AW  index of entry currently loaded/running
done  output  1  one-cycle pulse on normal sequence completion

Behaviour:
- One clock, synchronous active-high reset. All outputs registered.
- Reset: state IDLE; table entries = 0x00; data_out=0x00, load=0, re_load=0, busy=0, seq_idx=0, done=0; captured last_idx/loop_en = 0.
- Table write: on any edge with wr_en=1, table[wr_addr] <= wr_data, in any state. A read and a write to the same entry on the same edge return the OLD value (read-before-write).
- FSM states: IDLE, LOAD, ARM, RUN.
- IDLE: busy=0. On start=1 and stop=0:
  - capture last_idx and loop_en;
  - idx <= 0; data_out <= table[0]; next state LOAD.
- LOAD (exactly 1 cycle): load=1, busy=1; next ARM.
- ARM (exactly 1 cycle): re_load=1; next RUN.
- RUN: waits for tc_in. On tc_in=1:
  - idx < captured last_idx: idx <= idx+1, data_out <= table[idx+1], next LOAD.
  - idx == last_idx and loop_en=1: idx <= 0, data_out <= table[0], next LOAD.
  - idx == last_idx and loop_en=0: next IDLE, done=1 for the first IDLE cycle only.
- Latency:
  - Start sampled at edge E0: LOAD in cycle E0+1, re_load in E0+2, RUN from E0+3.
  - tc_in sampled at edge Ek in RUN: next load in Ek+1, re_load in Ek+2.
- load and re_load are never high in the same cycle. Each is high for exactly 1 cycle per entry.
- seq_idx mirrors idx; it is held in IDLE after completion or abort.
- stop=1 in LOAD/ARM/RUN: next state IDLE, no done, no further strobes. stop has priority over tc_in and start. stop in IDLE has no effect.
- start while busy is ignored; the captured last_idx/loop_en are unchanged.
- tc_in outside RUN (IDLE, LOAD, ARM) is ignored; it does not advance the sequence.
- Entry value 0x00 is passed through unmodified; no special casing.
- last_idx changes during a run have no effect until the next accepted start.
- Reset mid-sequence: the next cycle matches the reset state. The table is cleared.
- The counter stage also self-restarts on its own tc. The following load/re_load pair overrides this with the new entry; no action is required here.

Test Plan:
- Write table {0x05,0x0A,0x03,0xFF}, last_idx=2, loop_en=0, pulse start; pulse tc_in 3 times in RUN -> load/data_out sequence 0x05,0x0A,0x03; each re_load exactly 1 cycle after load; one done pulse; busy=0 afterward; 0xFF never output.
- Same table, last_idx=1, loop_en=1; 5 tc_in pulses -> data_out 0x05,0x0A,0x05,0x0A,0x05,0x0A (6 loads); seq_idx wraps 1->0; no done.
- Start, then stop during RUN of entry 1 -> IDLE next cycle; no done, no load/re_load afterward; seq_idx holds 1; a subsequent start restarts at entry 0.
- Assert start during RUN and tc_in during LOAD/ARM -> both ignored: idx unchanged, no extra strobes, timing of next load unaffected.
- Write table[1]=0x77 on the same edge that tc_in advances to entry 1 -> data_out = old table[1]. A second pass (loop_en=1) outputs 0x77.
- Assert rst mid-RUN -> next cycle all outputs 0 and state IDLE. A new start with no writes outputs data_out=0x00.
